// File: rtl/pwm_axil_arbiter.sv
// pwm_axil_arbiter
//   Two-requester round-robin arbiter that shares one AXI4-Lite master port
//   to the switch_led_out/PWM slave register bank. Requester 0 is the command
//   path and requester 1 is the steering/speed controller. Each requester uses
//   a simple req/ack register-access port. Exactly one AXI transaction is in
//   flight at a time.
//
//   Optional feature macro: PWM_ARB_WR_VERIFY_EN
//     When defined, every write with an OKAY bresp is read back from the same
//     address. A readback mismatch acks with resp=2'b10 and sets the sticky
//     vfy_err flag. When undefined, vfy_err is tied to 0.
//
// Ports
//   ACLK, ARESETN       clock (rising edge) / asynchronous active-low reset
//   req[1:0], we[1:0]   per-requester request and write(1)/read(0) select
//   addr, wdata         requester i payload at [i*ADDR_W +: ADDR_W] / [i*DATA_W +: DATA_W]
//   ack[1:0]            one-cycle completion pulse to the granted requester
//   rdata, resp         read data / AXI response, valid while an ack bit is high
//   grant[1:0]          one-hot owner of the current transaction, 0 when idle
//   vfy_err             sticky write-verify mismatch flag
//   m_axi_*             AXI4-Lite master (AW, W, B, AR, R channels)
module pwm_axil_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [2*ADDR_W-1:0]   addr,
  input  logic [2*DATA_W-1:0]   wdata,
  output logic [1:0]            ack,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            resp,
  output logic [1:0]            grant,
  output logic                  vfy_err,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_B,
    RD,
    RD_R
`ifdef PWM_ARB_WR_VERIFY_EN
    ,
    VFY_AR,
    VFY_R
`endif
  } state_t;

  state_t              state;
  logic                last;
  logic                win;
  logic                start;
  logic                win_we;
  logic                wr_aw_done;
  logic                wr_w_done;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  // Round-robin pick: on a tie the requester that did not win last time goes.
  // Arbitration is held off while ack is high because a requester only sees
  // its ack in that cycle and cannot have dropped req yet.
  always_comb begin
    win = req[1];
    if (req == 2'b11) win = ~last;
    win_we = win ? we[1] : we[0];
    start  = (state == IDLE) && (req != 2'b00) && (ack == 2'b00);
  end

  // A channel is finished once its valid has dropped or is handshaking now.
  assign wr_aw_done = ~m_axi_awvalid | m_axi_awready;
  assign wr_w_done  = ~m_axi_wvalid  | m_axi_wready;

  // Payload is captured only at grant time, so it is stable under any valid.
  always_ff @(posedge ACLK) begin
    if (start) begin
      addr_q  <= win ? addr[2*ADDR_W-1:ADDR_W]  : addr[ADDR_W-1:0];
      wdata_q <= win ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
    end
  end

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = {(DATA_W/8){1'b1}};
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;

`ifdef PWM_ARB_WR_VERIFY_EN
  logic vfy_err_q;
  assign vfy_err = vfy_err_q;
`else
  assign vfy_err = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= IDLE;
      last          <= 1'b1;
      grant         <= 2'b00;
      ack           <= 2'b00;
      rdata         <= '0;
      resp          <= 2'b00;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
`ifdef PWM_ARB_WR_VERIFY_EN
      vfy_err_q     <= 1'b0;
`endif
    end else begin
      ack <= 2'b00;
      case (state)
        IDLE: begin
          if (start) begin
            grant <= win ? 2'b10 : 2'b01;
            last  <= win;
            if (win_we) begin
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= WR;
            end else begin
              m_axi_arvalid <= 1'b1;
              state         <= RD;
            end
          end
        end
        // AW and W complete independently, in either order.
        WR: begin
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
          if (wr_aw_done && wr_w_done) begin
            m_axi_bready <= 1'b1;
            state        <= WR_B;
          end
        end
        WR_B: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
`ifdef PWM_ARB_WR_VERIFY_EN
            if (m_axi_bresp == 2'b00) begin
              m_axi_arvalid <= 1'b1;
              state         <= VFY_AR;
            end else begin
              resp  <= m_axi_bresp;
              ack   <= grant;
              grant <= 2'b00;
              state <= IDLE;
            end
`else
            resp  <= m_axi_bresp;
            ack   <= grant;
            grant <= 2'b00;
            state <= IDLE;
`endif
          end
        end
        RD: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RD_R;
          end
        end
        RD_R: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rdata        <= m_axi_rdata;
            resp         <= m_axi_rresp;
            ack          <= grant;
            grant        <= 2'b00;
            state        <= IDLE;
          end
        end
`ifdef PWM_ARB_WR_VERIFY_EN
        VFY_AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= VFY_R;
          end
        end
        // Readback compared against the data we wrote; mismatch is sticky.
        VFY_R: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rdata        <= m_axi_rdata;
            ack          <= grant;
            grant        <= 2'b00;
            state        <= IDLE;
            if (m_axi_rdata == wdata_q) begin
              resp <= 2'b00;
            end else begin
              resp      <= 2'b10;
              vfy_err_q <= 1'b1;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_axil_arbiter.sv
// tb_pwm_axil_arbiter
//   Self-checking bench for pwm_axil_arbiter. A behavioural AXI4-Lite slave
//   with a small register memory answers the arbiter; expected completions
//   are queued when each access is issued and compared when ack pulses.
//   Build with PWM_ARB_WR_VERIFY_EN defined to cover the write-verify path.
module tb_pwm_axil_arbiter;

  logic        tb_ACLK;
  logic        ARESETN;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [1:0]  ack;
  logic [31:0] rdata;
  logic [1:0]  resp;
  logic [1:0]  grant;
  logic        vfy_err;
  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  pwm_axil_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .ACLK(tb_ACLK), .ARESETN(ARESETN),
    .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .resp(resp), .grant(grant), .vfy_err(vfy_err),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  initial tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

`ifdef PWM_ARB_WR_VERIFY_EN
  localparam int WR_LAT = 5;
`else
  localparam int WR_LAT = 3;
`endif

  // ---------------- behavioural AXI4-Lite slave ----------------
  logic        wdelay, b_stall, err_rd, corrupt;
  logic [31:0] mem [16];
  logic        aw_got, w_got, aw_seen;
  logic [1:0]  w_wait;
  logic [31:0] wa, wd;
  logic        awhs, whs;
  logic [31:0] wr_a, wr_d;

  assign m_axi_awready = 1'b1;
  assign m_axi_arready = 1'b1;
  assign m_axi_wready  = !wdelay || (aw_seen && (w_wait == 2'd0));
  assign m_axi_bresp   = 2'b00;
  assign awhs = m_axi_awvalid && m_axi_awready;
  assign whs  = m_axi_wvalid && m_axi_wready;
  assign wr_a = awhs ? m_axi_awaddr : wa;
  assign wr_d = whs ? m_axi_wdata : wd;

  always @(posedge tb_ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_got       <= 1'b0;
      w_got        <= 1'b0;
      aw_seen      <= 1'b0;
      w_wait       <= 2'd0;
      m_axi_bvalid <= 1'b0;
      m_axi_rvalid <= 1'b0;
      m_axi_rdata  <= 32'h0;
      m_axi_rresp  <= 2'b00;
    end else begin
      if (awhs) begin
        aw_got  <= 1'b1;
        wa      <= m_axi_awaddr;
        aw_seen <= 1'b1;
        w_wait  <= 2'd2;
      end else if (w_wait != 2'd0) begin
        w_wait <= w_wait - 2'd1;
      end
      if (whs) begin
        w_got   <= 1'b1;
        wd      <= m_axi_wdata;
        aw_seen <= 1'b0;
      end
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      if ((aw_got || awhs) && (w_got || whs) && !b_stall) begin
        m_axi_bvalid    <= 1'b1;
        mem[wr_a[5:2]]  <= wr_d;
        aw_got          <= 1'b0;
        w_got           <= 1'b0;
      end
      if (m_axi_arvalid && m_axi_arready) begin
        m_axi_rvalid <= 1'b1;
        m_axi_rdata  <= mem[m_axi_araddr[5:2]] ^ (corrupt ? 32'h1 : 32'h0);
        m_axi_rresp  <= (err_rd && m_axi_araddr == 32'hC) ? 2'b10 : 2'b00;
      end else if (m_axi_rvalid && m_axi_rready) begin
        m_axi_rvalid <= 1'b0;
      end
    end
  end

  // ---------------- checking and scoreboard ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  typedef struct packed {
    logic [1:0]  id;
    logic [1:0]  resp;
    logic        is_rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];

  task automatic push_exp(input logic [1:0] id, input logic [1:0] r, input logic rd, input logic [31:0] d);
    exp_t e;
    e.id = id; e.resp = r; e.is_rd = rd; e.rdata = d;
    sb_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge tb_ACLK);
      if (ARESETN && ack != 2'b00) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_ack", {62'h0, ack}, 64'h0);
        end else begin
          e = sb_q.pop_front();
          check_eq("sb_ack", {62'h0, ack}, {62'h0, 2'b01 << e.id});
          check_eq("sb_resp", {62'h0, resp}, {62'h0, e.resp});
          if (e.is_rd) check_eq("sb_rdata", {32'h0, rdata}, {32'h0, e.rdata});
        end
      end
    end
  end

  // Drive requester i and hold req for n acks; report first-ack latency and
  // how many cycles awvalid/wvalid were high during the first access.
  task automatic do_burst(input int i, input int n, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output int awc, output int wc);
    int cyc;
    lat = 0; awc = 0; wc = 0;
    we[i] = w;
    addr[i*32 +: 32]  = a;
    wdata[i*32 +: 32] = d;
    req[i] = 1'b1;
    for (int k = 0; k < n; k++) begin
      cyc = 0;
      do begin
        @(negedge tb_ACLK);
        cyc++;
        if (k == 0) begin
          if (m_axi_awvalid) awc++;
          if (m_axi_wvalid) wc++;
        end
      end while (!ack[i] && cyc < 100);
      if (k == 0) lat = cyc;
      check_eq("ack_seen", {63'h0, ack[i]}, 64'h1);
    end
    req[i] = 1'b0;
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    repeat (2) @(negedge tb_ACLK);
    ARESETN = 1'b1;
    @(negedge tb_ACLK);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat, awc, wc, l0, a0, w0, l1, a1, w1, cyc;
    ARESETN = 1'b0;
    req = 2'b00; we = 2'b00; addr = '0; wdata = '0;
    wdelay = 1'b0; b_stall = 1'b0; err_rd = 1'b0; corrupt = 1'b0;
    @(negedge tb_ACLK);
    check_eq("rst_ack", {62'h0, ack}, 64'h0);
    check_eq("rst_grant", {62'h0, grant}, 64'h0);
    check_eq("rst_valids", {60'h0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready}, 64'h0);
    check_eq("rst_rready", {63'h0, m_axi_rready}, 64'h0);
    check_eq("rst_rdata_resp", {30'h0, rdata, resp}, 64'h0);
    check_eq("rst_vfy_err", {63'h0, vfy_err}, 64'h0);
    @(negedge tb_ACLK);
    ARESETN = 1'b1;
    @(negedge tb_ACLK);

    // 1) single write with cycle-exact timing, then read back
    push_exp(2'd0, 2'b00, 1'b0, 32'h0);
    we[0] = 1'b1; addr[31:0] = 32'h0; wdata[31:0] = 32'h0101FFFF; req[0] = 1'b1;
    @(negedge tb_ACLK);
    check_eq("t1_aw_w_valid", {62'h0, m_axi_awvalid, m_axi_wvalid}, 64'h3);
    check_eq("t1_grant", {62'h0, grant}, 64'h1);
    check_eq("t1_awaddr_strb_prot", {m_axi_awaddr, 21'h0, m_axi_awprot, 4'h0, m_axi_wstrb},
             {32'h0, 21'h0, 3'b000, 4'h0, 4'hF});
    @(negedge tb_ACLK);
    check_eq("t1_bready", {62'h0, m_axi_bready, m_axi_awvalid}, 64'h2);
    repeat (WR_LAT - 3) @(negedge tb_ACLK);
    check_eq("t1_ack_early", {62'h0, ack}, 64'h0);
    @(negedge tb_ACLK);
    check_eq("t1_ack", {62'h0, ack}, 64'h1);
    check_eq("t1_grant_clear", {62'h0, grant}, 64'h0);
    req[0] = 1'b0;
    @(negedge tb_ACLK);
    push_exp(2'd0, 2'b00, 1'b1, 32'h0101FFFF);
    do_burst(0, 1, 1'b0, 32'h0, 32'h0, lat, awc, wc);
    check_eq("t1_rd_latency", lat, 3);

    // 2) simultaneous requests after reset, held for two accesses each
    do_reset();
    push_exp(2'd0, 2'b00, 1'b0, 32'h0);
    push_exp(2'd1, 2'b00, 1'b0, 32'h0);
    push_exp(2'd0, 2'b00, 1'b0, 32'h0);
    push_exp(2'd1, 2'b00, 1'b0, 32'h0);
    fork
      do_burst(0, 2, 1'b1, 32'h4, 32'hA5A50004, l0, a0, w0);
      do_burst(1, 2, 1'b1, 32'h8, 32'h5A5A0008, l1, a1, w1);
    join
    @(negedge tb_ACLK);
    push_exp(2'd1, 2'b00, 1'b1, 32'hA5A50004);
    do_burst(1, 1, 1'b0, 32'h4, 32'h0, lat, awc, wc);
    @(negedge tb_ACLK);
    push_exp(2'd0, 2'b00, 1'b1, 32'h5A5A0008);
    do_burst(0, 1, 1'b0, 32'h8, 32'h0, lat, awc, wc);
    @(negedge tb_ACLK);

    // 3) wready delayed 3 cycles after the AW handshake
    wdelay = 1'b1;
    push_exp(2'd0, 2'b00, 1'b0, 32'h0);
    do_burst(0, 1, 1'b1, 32'hC, 32'h12345678, lat, awc, wc);
    check_eq("t3_awvalid_cycles", awc, 1);
    check_eq("t3_wvalid_cycles", wc, 4);
    wdelay = 1'b0;
    @(negedge tb_ACLK);

    // 4) error rresp on 0xC, then a normal access
    err_rd = 1'b1;
    push_exp(2'd0, 2'b10, 1'b1, 32'h12345678);
    do_burst(0, 1, 1'b0, 32'hC, 32'h0, lat, awc, wc);
    err_rd = 1'b0;
    @(negedge tb_ACLK);
    push_exp(2'd1, 2'b00, 1'b1, 32'h5A5A0008);
    do_burst(1, 1, 1'b0, 32'h8, 32'h0, lat, awc, wc);
    @(negedge tb_ACLK);

    // 5) reset asserted while waiting in WR_B
    b_stall = 1'b1;
    we[0] = 1'b1; addr[31:0] = 32'h10; wdata[31:0] = 32'h00000055; req[0] = 1'b1;
    cyc = 0;
    do begin
      @(negedge tb_ACLK);
      cyc++;
    end while (!m_axi_bready && cyc < 20);
    check_eq("t5_in_wr_b", {63'h0, m_axi_bready}, 64'h1);
    #2 ARESETN = 1'b0;
    #1;
    check_eq("t5_rst_outputs", {57'h0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
             m_axi_bready, m_axi_rready, grant}, 64'h0);
    check_eq("t5_rst_ack", {62'h0, ack}, 64'h0);
    req[0] = 1'b0;
    b_stall = 1'b0;
    repeat (2) @(negedge tb_ACLK);
    ARESETN = 1'b1;
    repeat (2) @(negedge tb_ACLK);
    push_exp(2'd1, 2'b00, 1'b1, 32'h0101FFFF);
    do_burst(1, 1, 1'b0, 32'h0, 32'h0, lat, awc, wc);
    @(negedge tb_ACLK);

`ifdef PWM_ARB_WR_VERIFY_EN
    // 6) readback differs from the stored value
    corrupt = 1'b1;
    push_exp(2'd0, 2'b10, 1'b0, 32'h0);
    do_burst(0, 1, 1'b1, 32'h14, 32'hDEAD0011, lat, awc, wc);
    check_eq("t6_wr_latency", lat, 5);
    corrupt = 1'b0;
    @(negedge tb_ACLK);
    check_eq("t6_vfy_err_set", {63'h0, vfy_err}, 64'h1);
    push_exp(2'd1, 2'b00, 1'b1, 32'hDEAD0011);
    do_burst(1, 1, 1'b0, 32'h14, 32'h0, lat, awc, wc);
    @(negedge tb_ACLK);
    check_eq("t6_vfy_err_sticky", {63'h0, vfy_err}, 64'h1);
`else
    check_eq("vfy_err_tied", {63'h0, vfy_err}, 64'h0);
`endif

    repeat (3) @(negedge tb_ACLK);
    check_eq("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
